// File: rtl/draw_port_arbiter_pkg.sv
// Shared types and constants for the framebuffer write-port arbiter.
// Optional watchdog is enabled with DRAW_ARB_WATCHDOG_EN (see draw_port_arbiter.sv).
package draw_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam int DEF_XW = 10;
  localparam int DEF_YW = 10;
  localparam int DEF_CW = 3;

  // Requester slots as wired in the game datapath
  localparam int BALL   = 0;
  localparam int PADDLE = 1;
  localparam int BRICK  = 2;
  localparam int ERASE  = 3;

endpackage

// File: rtl/draw_port_arbiter_if.sv
// Bundle between the draw engines (master) and the port arbiter (slave).
interface draw_port_arbiter_if
  import draw_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int XW      = DEF_XW,
  parameter int YW      = DEF_YW,
  parameter int CW      = DEF_CW
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    done;
  logic [NUM_REQ-1:0]    wr_en;
  logic [NUM_REQ*XW-1:0] x_in;
  logic [NUM_REQ*YW-1:0] y_in;
  logic [NUM_REQ*CW-1:0] colour_in;
  logic [NUM_REQ-1:0]    grant;
  logic [XW-1:0]         vga_x;
  logic [YW-1:0]         vga_y;
  logic [CW-1:0]         vga_colour;
  logic                  vga_plot;
  logic                  busy;
  logic                  timeout_err;

  modport master (
    output req, done, wr_en, x_in, y_in, colour_in,
    input  grant, vga_x, vga_y, vga_colour, vga_plot, busy, timeout_err
  );

  modport slave (
    input  req, done, wr_en, x_in, y_in, colour_in,
    output grant, vga_x, vga_y, vga_colour, vga_plot, busy, timeout_err
  );
endinterface

// File: rtl/draw_port_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [IW-1:0]      winner_o,
  output logic               valid_o
);
  localparam int SW = IW + 1;

  logic [SW-1:0] sum_s;
  logic [IW-1:0] idx_s;

  // Scan from the farthest slot back to ptr so the nearest set bit is written last
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    sum_s    = '0;
    idx_s    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum_s = {1'b0, ptr_i} + SW'(k);
      if (sum_s >= SW'(NUM_REQ)) begin
        idx_s = IW'(sum_s - SW'(NUM_REQ));
      end else begin
        idx_s = sum_s[IW-1:0];
      end
      winner_o = req_i[idx_s] ? idx_s : winner_o;
      valid_o  = valid_o | req_i[idx_s];
    end
  end
endmodule

// File: rtl/draw_port_arbiter.sv
// Round-robin arbiter sharing the VGA framebuffer write port among draw engines.
// Define DRAW_ARB_WATCHDOG_EN to force release of a grant held for MAX_HOLD DRAW cycles.
module draw_port_arbiter
  import draw_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int XW       = DEF_XW,
  parameter int YW       = DEF_YW,
  parameter int CW       = DEF_CW,
  parameter int MAX_HOLD = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  draw_port_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      w_q, w_d;
  logic [IW-1:0]      pick_w_s;
  logic               pick_v_s;
  logic               wd_fire_s;
  logic               in_draw_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    wrap_inc = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
  endfunction

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .winner_o (pick_w_s),
    .valid_o  (pick_v_s)
  );

  // Next-state logic; done and req-drop in the same cycle are one release
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    w_d     = w_q;
    case (state_q)
      IDLE: begin
        if (pick_v_s) begin
          state_d = DRAW;
          grant_d = onehot(pick_w_s);
          w_d     = pick_w_s;
        end else begin
          state_d = IDLE;
        end
      end
      DRAW: begin
        if (bus.done[w_q] || !bus.req[w_q] || wd_fire_s) begin
          state_d = GAP;
          grant_d = '0;
          ptr_d   = wrap_inc(w_q);
        end else begin
          state_d = DRAW;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
    end
  end

`ifdef DRAW_ARB_WATCHDOG_EN
  localparam int HW = $clog2(MAX_HOLD) + 1;

  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;

  assign wd_fire_s = in_draw_s && (hold_q == HW'(MAX_HOLD - 1))
                     && bus.req[w_q] && !bus.done[w_q];

  // Hold counter is zero on every DRAW entry because it clears outside DRAW
  always_comb begin
    hold_d    = in_draw_s ? hold_q + HW'(1) : '0;
    timeout_d = timeout_q | wd_fire_s;
  end

  // Watchdog registers; timeout stays set until reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_err = timeout_q;
`else
  assign wd_fire_s       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign in_draw_s      = (state_q == DRAW);
  assign bus.grant      = grant_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.vga_x      = in_draw_s ? bus.x_in[w_q*XW +: XW] : '0;
  assign bus.vga_y      = in_draw_s ? bus.y_in[w_q*YW +: YW] : '0;
  assign bus.vga_colour = in_draw_s ? bus.colour_in[w_q*CW +: CW] : '0;
  assign bus.vga_plot   = in_draw_s & bus.wr_en[w_q] & grant_q[w_q];
endmodule

// File: tb/tb_draw_port_arbiter.sv
// Self-checking bench for draw_port_arbiter: directed scenarios plus random traffic vs a behavioural model.
module tb_draw_port_arbiter;
  import draw_arb_pkg::*;

  localparam int N = 4;
`ifdef DRAW_ARB_WATCHDOG_EN
  localparam int MH = 8;
`else
  localparam int MH = 1024;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  draw_port_arbiter_if #(.NUM_REQ(N), .XW(DEF_XW), .YW(DEF_YW), .CW(DEF_CW)) bus ();

  draw_port_arbiter #(
    .NUM_REQ(N), .XW(DEF_XW), .YW(DEF_YW), .CW(DEF_CW), .MAX_HOLD(MH)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the port, remaining forced-idle cycles, next search start
  int m_owner, m_gap, m_ptr, m_hold;
  logic m_to;

  int mode;
  logic [N-1:0] req_v, wr_v;
  int k_done [N];
  logic [9:0] ex [N];
  logic [9:0] ey [N];
  logic [2:0] ec [N];

  int plots, pl57, x300, g0cnt;
  logic [N-1:0] prev_grant;
  logic [N-1:0] glog [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_ptr = 0; m_hold = 0; m_to = 1'b0;
  endtask

  task automatic model_update();
    logic rel, wd;
    if (m_owner >= 0) begin
      rel = bus.done[m_owner] || !bus.req[m_owner];
`ifdef DRAW_ARB_WATCHDOG_EN
      wd = !rel && (m_hold == MH - 1);
`else
      wd = 1'b0;
`endif
      if (wd) m_to = 1'b1;
      if (rel || wd) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        m_gap = 1;
      end else begin
        m_hold++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 0; k < N; k++)
        if (m_owner < 0 && bus.req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      m_hold = 0;
    end
  endtask

  task automatic drive();
    logic [N-1:0] d;
    if (mode == 2) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) req_v[i] = ~req_v[i];
        ex[i] = 10'($urandom);
        ey[i] = 10'($urandom);
        ec[i] = 3'($urandom);
      end
      wr_v = N'($urandom);
    end else if (mode == 1) begin
      wr_v[1] = 1'($urandom_range(0, 1));
      wr_v[3] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < N; i++)
      d[i] = (m_owner == i) && (m_hold == k_done[i] - 1);
    if (mode == 1) d[3] = 1'($urandom_range(0, 1));
    if (mode == 2)
      for (int i = 0; i < N; i++) d[i] = d[i] | ($urandom_range(0, 5) == 0);
    bus.req   = req_v;
    bus.done  = d;
    bus.wr_en = wr_v;
    for (int i = 0; i < N; i++) begin
      bus.x_in[i*DEF_XW +: DEF_XW]      = ex[i];
      bus.y_in[i*DEF_YW +: DEF_YW]      = ey[i];
      bus.colour_in[i*DEF_CW +: DEF_CW] = ec[i];
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    logic ep;
    logic [9:0] exx, eyy;
    logic [2:0] ecc;
    eg = '0; ep = 1'b0; exx = '0; eyy = '0; ecc = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ep  = bus.wr_en[m_owner];
      exx = ex[m_owner];
      eyy = ey[m_owner];
      ecc = ec[m_owner];
    end
    check_eq("grant", 32'(bus.grant), 32'(eg));
    check_eq("vga_plot", 32'(bus.vga_plot), 32'(ep));
    check_eq("vga_x", 32'(bus.vga_x), 32'(exx));
    check_eq("vga_y", 32'(bus.vga_y), 32'(eyy));
    check_eq("vga_colour", 32'(bus.vga_colour), 32'(ecc));
    check_eq("busy", 32'(bus.busy), 32'((m_owner >= 0) || (m_gap > 0)));
    check_eq("timeout_err", 32'(bus.timeout_err), 32'(m_to));
  endtask

  // One clock: drive at negedge, check shortly after, advance model at posedge
  task automatic step();
    drive();
    #1;
    check_outputs();
    if (bus.vga_plot) plots++;
    if (bus.vga_plot && bus.vga_x == 10'd5 && bus.vga_y == 10'd7 && bus.vga_colour == 3'd5) pl57++;
    if (bus.vga_x == 10'd300) x300++;
    if (bus.grant == 4'b0001) g0cnt++;
    if (bus.grant != 4'b0000 && bus.grant != prev_grant) glog.push_back(bus.grant);
    prev_grant = bus.grant;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic clear_stats();
    plots = 0; pl57 = 0; x300 = 0; g0cnt = 0;
    glog.delete();
  endtask

  task automatic reset_dut();
    mode = 0; req_v = '0; wr_v = '0;
    for (int i = 0; i < N; i++) begin
      k_done[i] = 2; ex[i] = '0; ey[i] = '0; ec[i] = '0;
    end
    bus.req = '0; bus.done = '0; bus.wr_en = '0;
    bus.x_in = '0; bus.y_in = '0; bus.colour_in = '0;
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_grant", 32'(bus.grant), 32'd0);
    check_eq("rst_plot", 32'(bus.vga_plot), 32'd0);
    check_eq("rst_x", 32'(bus.vga_x), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_timeout", 32'(bus.timeout_err), 32'd0);
    model_reset();
    prev_grant = '0;
    clear_stats();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    reset_dut();

    // Single requester: 4 plots at (5,7), then re-grant after GAP+IDLE
    req_v = 4'b0001; wr_v = 4'b0001; k_done[BALL] = 4;
    ex[BALL] = 10'd5; ey[BALL] = 10'd7; ec[BALL] = 3'd5;
    run(7);
    check_eq("single_plots", 32'(pl57), 32'd4);
    check_eq("single_plots_all", 32'(plots), 32'd4);
    run(2);
    check_eq("single_regrant_cnt", 32'(glog.size()), 32'd2);
    check_eq("single_regrant", 32'(glog[1]), 32'd1);

    // Round-robin with all engines requesting
    reset_dut();
    req_v = 4'b1111; wr_v = 4'b1111;
    for (int i = 0; i < N; i++) k_done[i] = 2;
    run(18);
    check_eq("rr_len_ok", 32'(glog.size() >= 5), 32'd1);
    check_eq("rr_0", 32'(glog[0]), 32'h1);
    check_eq("rr_1", 32'(glog[1]), 32'h2);
    check_eq("rr_2", 32'(glog[2]), 32'h4);
    check_eq("rr_3", 32'(glog[3]), 32'h8);
    check_eq("rr_4", 32'(glog[4]), 32'h1);

    // Rotation from ptr=1: engine 2 before engine 0
    reset_dut();
    req_v = 4'b0001; k_done[BALL] = 1;
    run(3);
    glog.delete();
    req_v = 4'b0101; k_done[BALL] = 2; k_done[BRICK] = 2;
    run(10);
    check_eq("rot_first", 32'(glog[0]), 32'h4);
    check_eq("rot_second", 32'(glog[1]), 32'h1);

    // Interference from a non-granted engine
    reset_dut();
    mode = 1; req_v = 4'b0010; k_done[PADDLE] = 6;
    ex[PADDLE] = 10'd17; ex[ERASE] = 10'd300; ey[ERASE] = 10'd300;
    run(30);
    check_eq("no_foreign_x", 32'(x300), 32'd0);

    // Reset in the middle of an ERASE draw
    reset_dut();
    req_v = 4'b1000; wr_v = 4'b1000; k_done[ERASE] = 100;
    run(3);
    drive();
    #1;
    check_eq("pre_rst_grant", 32'(bus.grant), 32'h8);
    check_eq("pre_rst_plot", 32'(bus.vga_plot), 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_grant", 32'(bus.grant), 32'd0);
    check_eq("mid_rst_plot", 32'(bus.vga_plot), 32'd0);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    reset_dut();
    req_v = 4'b1111; wr_v = 4'b1111;
    run(4);
    check_eq("ptr_after_rst", 32'(glog[0]), 32'h1);

    // Engine 0 holds without done
    reset_dut();
    req_v = 4'b0011; wr_v = 4'b0011; k_done[BALL] = 5000; k_done[PADDLE] = 2;
`ifdef DRAW_ARB_WATCHDOG_EN
    run(10);
    check_eq("wd_hold_cycles", 32'(g0cnt), 32'd8);
    check_eq("wd_flag", 32'(bus.timeout_err), 32'd1);
    run(10);
    check_eq("wd_next", 32'(glog[1]), 32'h2);
    check_eq("wd_sticky", 32'(bus.timeout_err), 32'd1);
`else
    run(40);
    check_eq("hold_cycles", 32'(g0cnt), 32'd39);
    check_eq("hold_grants", 32'(glog.size()), 32'd1);
    check_eq("no_timeout", 32'(bus.timeout_err), 32'd0);
`endif

    // Random traffic against the model
    reset_dut();
    mode = 2;
    for (int i = 0; i < N; i++) k_done[i] = 3;
    run(800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/draw_port_arbiter.md
Name: draw_port_arbiter

Overview:
- Shares the single VGA framebuffer write port between several draw engines: ball, paddle, brick field and eraser.
- Each engine requests the port and keeps its request high while it draws.
- The arbiter grants one engine at a time, round-robin, and forwards that engine's x/y/colour/write-enable to the VGA adapter.
- It sits between the draw engines and the VGA adapter in the top-level game datapath.

Parameters:
- NUM_REQ, 4: number of requesting draw engines; legal range 2..8.
- XW, 10: x coordinate width.
- YW, 10: y coordinate width.
- CW, 3: colour width.
- MAX_HOLD, 1024: watchdog limit in DRAW cycles per grant. Used only when the watchdog is compiled in.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; asynchronous assert, active-low.
- req  in  NUM_REQ  per-engine request; held high for the whole draw.
- done  in  NUM_REQ  per-engine one-cycle pulse on the last plotted pixel.
- wr_en  in  NUM_REQ  per-engine pixel write strobe.
- x_in  in  NUM_REQ*XW  packed engine x coordinates; engine i is at [i*XW +: XW].
- y_in  in  NUM_REQ*YW  packed engine y coordinates.
- colour_in  in  NUM_REQ*CW  packed engine colours.
- grant  out  NUM_REQ  one-hot grant, registered.
- vga_x  out  XW  forwarded x.
- vga_y  out  YW  forwarded y.
- vga_colour  out  CW  forwarded colour.
- vga_plot  out  1  forwarded write enable.
- busy  out  1  high when the state is not IDLE.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, grant=0, ptr=0, busy=0, timeout_err=0.
  - vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
  - A reset mid-draw drops grant and vga_plot immediately, without waiting for a clock edge.
- States: IDLE, DRAW, GAP.
- IDLE:
  - If req is nonzero, pick the winner w: the first set req bit searching upward from ptr, wrapping modulo NUM_REQ.
  - On the clock edge, grant<=onehot(w) and the state goes to DRAW.
  - Latency from req high at a clock edge to grant high is 1 cycle.
- DRAW:
  - vga_x/vga_y/vga_colour are a combinational mux of engine w's inputs.
  - vga_plot = wr_en[w] & grant[w].
  - Exit to GAP when done[w]=1 or req[w]=0 (both in the same cycle counts as a single release).
  - The edge that leaves DRAW also clears grant and sets ptr<=(w+1) mod NUM_REQ.
  - The cycle with done[w]=1 still forwards that cycle's pixel.
- GAP:
  - Exactly one cycle with grant=0 and vga_plot=0, so an engine can reload its coordinates.
  - Then return to IDLE. Requests are re-evaluated in IDLE, so back-to-back grants are separated by 2 idle cycles (GAP + IDLE).
- Outside DRAW, vga_x/vga_y/vga_colour/vga_plot are 0.
- Signals from non-granted engines (wr_en, done, req changes) are ignored.
- An engine that releases and immediately re-requests has lowest priority on the next arbitration.
- With a single requester, it is re-granted every 3 cycles until its req drops.
- A winner whose req is already low on the DRAW entry cycle exits after 1 DRAW cycle with no plot.
- Width rule: coordinates are passed through unmodified; no arithmetic on them.

Optional Feature:
- Macro: DRAW_ARB_WATCHDOG_EN.
- With the macro defined:
  - A hold counter clears on DRAW entry and increments every DRAW cycle.
  - If the counter reaches MAX_HOLD-1 without done[w] and with req[w] still high, the arbiter forces DRAW->GAP and sets timeout_err<=1, sticky until reset.
  - ptr advances past w as in a normal release.
- Without the macro: no counter, timeout_err is tied 0, and DRAW is held indefinitely.

Decomposition:
- Package draw_arb_pkg holds:
  - the state encoding constants IDLE/DRAW/GAP;
  - default widths XW=10, YW=10, CW=3;
  - requester index constants BALL=0, PADDLE=1, BRICK=2, ERASE=3.
- One sub-module: rr_pick, a combinational round-robin priority encoder. Inputs: req and ptr. Outputs: winner index and a valid flag.

Test Plan:
- Reset mid-draw: ERASE granted, pull resetn low between edges -> grant=0 and vga_plot=0 before the next clk edge; ptr=0 after release.
- Single requester: req=4'b0001 with x_in[0]=10'd5, y_in[0]=10'd7, wr_en[0]=1, done[0] after 4 cycles -> grant=0001 one edge after req; exactly 4 plots at (5,7), colour forwarded; GAP then IDLE; re-grant one cycle after IDLE if still requested.
- Round-robin: req=4'b1111 held, each engine pulses done after 2 DRAW cycles -> grant order 0001, 0010, 0100, 1000, 0001.
- Rotation from ptr: req=4'b0101 with ptr=1 -> engine 2 is granted first, then engine 0.
- Interference: engine 1 granted, engine 3 toggles wr_en/done with x=10'd300 -> vga_x never equals 300; vga_plot follows only wr_en[1].
- Watchdog (macro on, MAX_HOLD=8): engine 0 holds req and never pulses done -> forced release after 8 DRAW cycles; timeout_err=1 and stays 1; engine 1 is granted next.
